// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-ported unified memory between the instruction-fetch
//   port (if_*) and the data port (dm_*). One transaction is in flight at a
//   time: a grant latches the command, mem_request strobes for one cycle,
//   the arbiter waits for mem_valid, then pulses the granted port's valid.
//   Data requests win ties unless fetch has waited through STARVE_LIMIT
//   consecutive data grants.
//
// Ports
//   i_clk, i_rst        clock (rising edge), async active-low reset
//   i_if_request        fetch request level, held until o_if_valid
//   i_if_addr/_mask     fetch command
//   o_if_valid/_rdata   fetch response pulse / held instruction word
//   i_dm_request        data request level, held until o_dm_valid
//   i_dm_we_re          1 = store, 0 = load
//   i_dm_addr/_mask/_wdata  data command
//   o_dm_valid/_rdata   data response pulse / held load data
//   o_mem_request       one-cycle memory command strobe
//   o_mem_we_re/_addr/_mask/_wdata  latched command, stable through WAIT
//   i_mem_rdata         memory read data, qualified by i_mem_valid
//   i_mem_valid         memory completion pulse
module mem_arbiter #(
  parameter int unsigned ADDRESS      = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_if_request,
  input  logic [ADDRESS-1:0]    i_if_addr,
  input  logic [3:0]            i_if_mask,
  output logic                  o_if_valid,
  output logic [DATA_WIDTH-1:0] o_if_rdata,
  input  logic                  i_dm_request,
  input  logic                  i_dm_we_re,
  input  logic [ADDRESS-1:0]    i_dm_addr,
  input  logic [3:0]            i_dm_mask,
  input  logic [DATA_WIDTH-1:0] i_dm_wdata,
  output logic                  o_dm_valid,
  output logic [DATA_WIDTH-1:0] o_dm_rdata,
  output logic                  o_mem_request,
  output logic                  o_mem_we_re,
  output logic [ADDRESS-1:0]    o_mem_addr,
  output logic [3:0]            o_mem_mask,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  input  logic                  i_mem_valid
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_LIMIT);

  typedef enum logic [2:0] {
    StIdle,
    StIssueIf,
    StIssueDm,
    StWaitIf,
    StWaitDm,
    StResp
  } state_e;

  state_e r_state, w_state_next;

  logic                  r_we_re;
  logic [ADDRESS-1:0]    r_addr;
  logic [3:0]            r_mask;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_resp_dm;  // 1 when the transaction belongs to the data port
  logic [CntW-1:0]       r_starve_cnt;
  logic [DATA_WIDTH-1:0] r_if_rdata;
  logic [DATA_WIDTH-1:0] r_dm_rdata;

  logic w_starved;
  logic w_grant_dm;
  logic w_grant_if;

  // Fetch has sat through STARVE_LIMIT data grants: it takes the next slot.
  assign w_starved  = i_if_request && (r_starve_cnt == StarveMax);
  assign w_grant_dm = (r_state == StIdle) && i_dm_request && !w_starved;
  assign w_grant_if = (r_state == StIdle) && i_if_request && !w_grant_dm;

  // State register
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; mem_valid outside WAIT is ignored.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_grant_dm) begin
          w_state_next = StIssueDm;
        end else if (w_grant_if) begin
          w_state_next = StIssueIf;
        end
      end
      StIssueIf: w_state_next = StWaitIf;
      StIssueDm: w_state_next = StWaitDm;
      StWaitIf:  if (i_mem_valid) w_state_next = StResp;
      StWaitDm:  if (i_mem_valid) w_state_next = StResp;
      StResp:    w_state_next = StIdle;
      default:   w_state_next = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    o_mem_request = 1'b0;
    o_if_valid    = 1'b0;
    o_dm_valid    = 1'b0;
    unique case (r_state)
      StIssueIf, StIssueDm: o_mem_request = 1'b1;
      StResp: begin
        o_if_valid = !r_resp_dm;
        o_dm_valid = r_resp_dm;
      end
      default: ;
    endcase
    o_mem_we_re = r_we_re;
    o_mem_addr  = r_addr;
    o_mem_mask  = r_mask;
    o_mem_wdata = r_wdata;
    o_if_rdata  = r_if_rdata;
    o_dm_rdata  = r_dm_rdata;
  end

  // Command latch and starvation counter, updated at the grant edge.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_we_re      <= 1'b0;
      r_addr       <= '0;
      r_mask       <= '0;
      r_wdata      <= '0;
      r_resp_dm    <= 1'b0;
      r_starve_cnt <= '0;
    end else if (w_grant_dm) begin
      r_we_re   <= i_dm_we_re;
      r_addr    <= i_dm_addr;
      r_mask    <= i_dm_mask;
      r_wdata   <= i_dm_wdata;
      r_resp_dm <= 1'b1;
      if (!i_if_request) begin
        r_starve_cnt <= '0;
      end else if (r_starve_cnt != StarveMax) begin
        r_starve_cnt <= r_starve_cnt + CntW'(1);
      end
    end else if (w_grant_if) begin
      r_we_re      <= 1'b0;
      r_addr       <= i_if_addr;
      r_mask       <= i_if_mask;
      r_wdata      <= '0;
      r_resp_dm    <= 1'b0;
      r_starve_cnt <= '0;
    end
  end

  // Response data capture; stores leave the data-port read register alone.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else if (i_mem_valid) begin
      if (r_state == StWaitIf) begin
        r_if_rdata <= i_mem_rdata;
      end
      if ((r_state == StWaitDm) && !r_we_re) begin
        r_dm_rdata <= i_mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_request, dm_request, dm_we_re;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [3:0]  if_mask, dm_mask;
  logic        o_if_valid, o_dm_valid, o_mem_request, o_mem_we_re;
  logic [31:0] o_if_rdata, o_dm_rdata, o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_mask;
  logic [31:0] mem_rdata, auto_rdata, man_rdata;
  logic        mem_valid, auto_valid, man_valid;

  always #5 clk = ~clk;

  assign mem_valid = auto_valid | man_valid;
  assign mem_rdata = man_valid ? man_rdata : auto_rdata;

  mem_arbiter #(.ADDRESS(32), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_if_request (if_request),
    .i_if_addr    (if_addr),
    .i_if_mask    (if_mask),
    .o_if_valid   (o_if_valid),
    .o_if_rdata   (o_if_rdata),
    .i_dm_request (dm_request),
    .i_dm_we_re   (dm_we_re),
    .i_dm_addr    (dm_addr),
    .i_dm_mask    (dm_mask),
    .i_dm_wdata   (dm_wdata),
    .o_dm_valid   (o_dm_valid),
    .o_dm_rdata   (o_dm_rdata),
    .o_mem_request(o_mem_request),
    .o_mem_we_re  (o_mem_we_re),
    .o_mem_addr   (o_mem_addr),
    .o_mem_mask   (o_mem_mask),
    .o_mem_wdata  (o_mem_wdata),
    .i_mem_rdata  (mem_rdata),
    .i_mem_valid  (mem_valid)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic        is_dm;
    logic [31:0] rdata;
  } resp_t;

  cmd_t  cmd_q[$];
  resp_t resp_q[$];

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_if_rdata = 32'h0;
  logic [31:0] m_dm_rdata = 32'h0;
  bit          mem_auto   = 1'b0;
  int          mem_lat    = 1;

  // Memory contents as seen by the responder.
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'h0050_0093;
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_dm(input logic we, input logic [31:0] addr, input logic [3:0] mask,
                           input logic [31:0] wdata);
    cmd_t  c;
    resp_t r;
    c = {we, addr, mask, wdata};
    cmd_q.push_back(c);
    if (!we) m_dm_rdata = mem_data(addr);
    r = {1'b1, m_dm_rdata};
    resp_q.push_back(r);
  endtask

  task automatic expect_if(input logic [31:0] addr, input logic [3:0] mask);
    cmd_t  c;
    resp_t r;
    c = {1'b0, addr, mask, 32'h0};
    cmd_q.push_back(c);
    m_if_rdata = mem_data(addr);
    r = {1'b0, m_if_rdata};
    resp_q.push_back(r);
  endtask

  // Wait for n valid pulses; drop a port's request on its pulse (drop_each) or all at the last.
  task automatic wait_valids(input int n, input int budget, input bit drop_each);
    int seen = 0;
    int t    = 0;
    while (seen < n && t < budget) begin
      @(negedge clk);
      t++;
      if (o_dm_valid) begin
        seen++;
        if (drop_each) dm_request = 1'b0;
      end
      if (o_if_valid) begin
        seen++;
        if (drop_each) if_request = 1'b0;
      end
    end
    dm_request = 1'b0;
    if_request = 1'b0;
    check("valid pulses seen", 64'(seen), 64'(n));
  endtask

  // Memory responder: answers each strobe after mem_lat cycles.
  initial begin : responder
    logic [31:0] a;
    auto_valid = 1'b0;
    auto_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (mem_auto && rst && o_mem_request) begin
        a = o_mem_addr;
        repeat (mem_lat) @(negedge clk);
        auto_rdata = mem_data(a);
        auto_valid = 1'b1;
        @(negedge clk);
        auto_valid = 1'b0;
      end
    end
  end

  // Monitor: pops expected commands on mem_request and expected responses on valid pulses.
  initial begin : monitor
    cmd_t  c, held, cur;
    resp_t r;
    bit    in_flight;
    in_flight = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        in_flight = 1'b0;
      end else begin
        cur = {o_mem_we_re, o_mem_addr, o_mem_mask, o_mem_wdata};
        if (o_mem_request) begin
          check("mem_request while busy", 64'(in_flight), 64'(0));
          if (cmd_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected mem_request: addr=%0h expected none", o_mem_addr);
          end else begin
            c = cmd_q.pop_front();
            check("cmd we_re", 64'(o_mem_we_re), 64'(c.we));
            check("cmd addr", 64'(o_mem_addr), 64'(c.addr));
            check("cmd mask", 64'(o_mem_mask), 64'(c.mask));
            check("cmd wdata", 64'(o_mem_wdata), 64'(c.wdata));
          end
          held      = cur;
          in_flight = 1'b1;
        end else if (in_flight && !(o_if_valid || o_dm_valid)) begin
          checks++;
          if (cur !== held) begin
            failures++;
            $display("FAIL cmd held: got %0h expected %0h", cur, held);
          end
        end
        if (o_if_valid || o_dm_valid) begin
          check("one valid at a time", 64'(o_if_valid && o_dm_valid), 64'(0));
          if (resp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected valid: if=%0b dm=%0b expected none", o_if_valid, o_dm_valid);
          end else begin
            r = resp_q.pop_front();
            check("resp port is_dm", 64'(o_dm_valid), 64'(r.is_dm));
            check("resp rdata", 64'(o_dm_valid ? o_dm_rdata : o_if_rdata), 64'(r.rdata));
          end
          in_flight = 1'b0;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int t;
    rst        = 1'b0;
    man_valid  = 1'b0;
    man_rdata  = 32'h0;
    if_request = 1'b1;
    dm_request = 1'b1;
    if_addr    = 32'h0000_0080;
    if_mask    = 4'hF;
    dm_we_re   = 1'b0;
    dm_addr    = 32'h0000_3000;
    dm_mask    = 4'hF;
    dm_wdata   = 32'h1111_1111;
    mem_auto   = 1'b1;
    mem_lat    = 1;

    // 1. Reset with both requests high, then data wins the first grant.
    repeat (3) @(negedge clk);
    check("reset mem_request", 64'(o_mem_request), 64'(0));
    check("reset if_valid", 64'(o_if_valid), 64'(0));
    check("reset dm_valid", 64'(o_dm_valid), 64'(0));
    check("reset mem_we_re", 64'(o_mem_we_re), 64'(0));
    check("reset mem_addr", 64'(o_mem_addr), 64'(0));
    check("reset mem_mask", 64'(o_mem_mask), 64'(0));
    check("reset mem_wdata", 64'(o_mem_wdata), 64'(0));
    check("reset if_rdata", 64'(o_if_rdata), 64'(0));
    check("reset dm_rdata", 64'(o_dm_rdata), 64'(0));
    expect_dm(1'b0, 32'h0000_3000, 4'hF, 32'h1111_1111);
    expect_if(32'h0000_0080, 4'hF);
    rst = 1'b1;
    wait_valids(2, 60, 1'b1);

    // 2. Single fetch, response two cycles after the strobe.
    repeat (2) @(negedge clk);
    mem_lat = 2;
    if_addr = 32'h0000_0100;
    expect_if(32'h0000_0100, 4'hF);
    if_request = 1'b1;
    wait_valids(1, 40, 1'b1);

    // 3. Store: load data register must not change.
    repeat (2) @(negedge clk);
    mem_lat  = 1;
    dm_we_re = 1'b1;
    dm_addr  = 32'h0000_2000;
    dm_mask  = 4'b0011;
    dm_wdata = 32'hDEAD_BEEF;
    expect_dm(1'b1, 32'h0000_2000, 4'b0011, 32'hDEAD_BEEF);
    dm_request = 1'b1;
    wait_valids(1, 40, 1'b1);
    check("store keeps dm_rdata", 64'(o_dm_rdata), 64'(32'h3000_CFFF));

    // 4. Contention: D,D,D,D,F,D,D,D,D,F.
    repeat (2) @(negedge clk);
    mem_lat  = 3;
    dm_we_re = 1'b0;
    dm_addr  = 32'h0000_5000;
    dm_mask  = 4'hF;
    dm_wdata = 32'h1111_1111;
    if_addr  = 32'h0000_0200;
    if_mask  = 4'hF;
    for (int i = 0; i < 10; i++) begin
      if (i % 5 == 4) expect_if(32'h0000_0200, 4'hF);
      else expect_dm(1'b0, 32'h0000_5000, 4'hF, 32'h1111_1111);
    end
    dm_request = 1'b1;
    if_request = 1'b1;
    wait_valids(10, 200, 1'b0);

    // 5. Reset during WAIT_DM drops the transaction.
    repeat (2) @(negedge clk);
    mem_auto = 1'b0;
    dm_addr  = 32'h0000_4000;
    dm_mask  = 4'b1000;
    dm_wdata = 32'h2222_2222;
    cmd_q.push_back({1'b0, 32'h0000_4000, 4'b1000, 32'h2222_2222});
    dm_request = 1'b1;
    t = 0;
    while (!o_mem_request && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("mid-op strobe seen", 64'(o_mem_request), 64'(1));
    @(negedge clk);
    dm_request = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("mid-op reset mem_addr", 64'(o_mem_addr), 64'(0));
    check("mid-op reset mem_request", 64'(o_mem_request), 64'(0));
    rst = 1'b1;
    m_if_rdata = 32'h0;
    m_dm_rdata = 32'h0;
    @(negedge clk);
    man_rdata = 32'h1234_5678;
    man_valid = 1'b1;
    @(negedge clk);
    man_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("dropped: no dm_valid", 64'(o_dm_valid), 64'(0));
      check("dropped: no mem_request", 64'(o_mem_request), 64'(0));
      @(negedge clk);
    end
    check("dropped: dm_rdata", 64'(o_dm_rdata), 64'(0));
    mem_auto = 1'b1;
    mem_lat  = 1;
    dm_addr  = 32'h0000_6000;
    dm_mask  = 4'b1100;
    dm_wdata = 32'h0;
    expect_dm(1'b0, 32'h0000_6000, 4'b1100, 32'h0);
    dm_request = 1'b1;
    wait_valids(1, 40, 1'b1);

    // 6. Spurious mem_valid in IDLE.
    repeat (2) @(negedge clk);
    man_rdata = 32'hBAD0_BAD0;
    man_valid = 1'b1;
    @(negedge clk);
    man_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("spurious: no if_valid", 64'(o_if_valid), 64'(0));
      check("spurious: no dm_valid", 64'(o_dm_valid), 64'(0));
      @(negedge clk);
    end
    check("spurious: dm_rdata kept", 64'(o_dm_rdata), 64'(m_dm_rdata));
    check("spurious: if_rdata kept", 64'(o_if_rdata), 64'(m_if_rdata));

    repeat (3) @(negedge clk);
    check("cmd queue drained", 64'(cmd_q.size()), 64'(0));
    check("resp queue drained", 64'(resp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
